// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl_pkg: slot states and display mode codes shared by the panel scanner
// and the HMI interface logic.
package seg_scan_ctrl_pkg;

    typedef enum logic {ST_BLANK, ST_ON} slot_st_t;

    localparam logic [2:0] SEG_CONST  = 3'd0;
    localparam logic [2:0] SEG_FLASH  = 3'd1;
    localparam logic [2:0] SEG_CURSOR = 3'd2;
    localparam logic [2:0] SEG_BLANK  = 3'd3;

    // Undefined mode codes behave as CONST.
    function automatic logic [2:0] seg_norm_mode(input logic [2:0] m);
        return (m > SEG_BLANK) ? SEG_CONST : m;
    endfunction

endpackage

// File: rtl/seg_flash_timer.sv
// seg_flash_timer: frame-based flash phase generator with blink counting; counting
// restarts (phase ON, counts 0) whenever the active display mode changes.
module seg_flash_timer #(
    parameter int FLASH_FRAMES = 50,
    parameter int FLASH_COUNT  = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic i_tick,
    input  logic i_mode_chg,
    input  logic i_flash_en,
    input  logic i_blink_en,
    output logic o_phase_on,
    output logic o_flash_done
);

    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam int BW = $clog2(FLASH_COUNT + 1);

    logic [FW-1:0] r_frame_cnt;
    logic [BW-1:0] r_blink_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_cnt  <= '0;
            r_blink_cnt  <= '0;
            o_phase_on   <= 1'b1;
            o_flash_done <= 1'b0;
        end else begin
            o_flash_done <= 1'b0;
            if (i_mode_chg) begin
                r_frame_cnt <= '0;
                r_blink_cnt <= '0;
                o_phase_on  <= 1'b1;
            end else if (i_tick && i_flash_en) begin
                if (r_frame_cnt == FW'(FLASH_FRAMES - 1)) begin
                    r_frame_cnt <= '0;
                    o_phase_on  <= ~o_phase_on;
                    // An OFF->ON transition completes one blink.
                    if (!o_phase_on && i_blink_en) begin
                        if (r_blink_cnt == BW'(FLASH_COUNT - 1)) begin
                            r_blink_cnt  <= '0;
                            o_flash_done <= 1'b1;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + 1'b1;
                        end
                    end
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment panel scanner with anti-ghost blanking,
// frame-aligned shadow registers and whole-panel / cursor-digit flashing.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int DIGITS       = 5,
    parameter int SCAN_DIV     = 20000,
    parameter int BLANK_CYC    = 200,
    parameter int FLASH_FRAMES = 50,
    parameter int FLASH_COUNT  = 5,
    parameter bit SEL_ACT_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8*DIGITS-1:0]   disp_data,
    input  logic [2:0]            disp_mode,
    input  logic [2:0]            cursor,
    input  logic                  load,
    output logic [DIGITS-1:0]     seg_select,
    output logic [7:0]            seg_out,
    output logic                  frame_start,
    output logic                  flash_done
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{SEL_ACT_LOW}};

    slot_st_t            r_state, w_state_nxt;
    logic [CW-1:0]       r_slot_cnt;
    logic [DW-1:0]       r_digit, w_digit_nxt;
    logic [8*DIGITS-1:0] r_pend_data, r_act_data;
    logic [2:0]          r_pend_mode, r_act_mode, r_pend_cur, r_act_cur;
    logic [2:0]          w_mode_in, w_mode_nxt;
    logic                w_slot_last, w_blank_last, w_boundary, w_mode_chg;
    logic                w_phase_on, w_cur_hit, w_gate_off;
    logic [7:0]          w_pat;
    logic [DIGITS-1:0]   w_sel_on;

    assign w_slot_last  = r_slot_cnt == CW'(SCAN_DIV - 1);
    assign w_blank_last = r_slot_cnt == CW'(BLANK_CYC - 1);
    assign w_boundary   = (r_state == ST_ON) && w_slot_last && (r_digit == DW'(DIGITS - 1));
    assign w_mode_in    = seg_norm_mode(disp_mode);
    assign w_mode_nxt   = load ? w_mode_in : r_pend_mode;
    assign w_mode_chg   = w_boundary && (w_mode_nxt != r_act_mode);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_BLANK;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_digit_nxt = r_digit;
        if (r_state == ST_BLANK && w_blank_last) begin
            w_state_nxt = ST_ON;
        end else if (r_state == ST_ON && w_slot_last) begin
            w_state_nxt = ST_BLANK;
            w_digit_nxt = (r_digit == DW'(DIGITS - 1)) ? '0 : r_digit + 1'b1;
        end
    end

    // Active regs and flash phase only change on the boundary edge, where the next
    // state is BLANK, so the output decode below never sees them mid-update.
    assign w_pat      = r_act_data[8*w_digit_nxt +: 8];
    assign w_cur_hit  = 32'(r_act_cur) == 32'(w_digit_nxt);
    assign w_gate_off = (r_act_mode == SEG_BLANK) ||
                        (!w_phase_on && ((r_act_mode == SEG_FLASH) ||
                                         (r_act_mode == SEG_CURSOR && w_cur_hit)));
    assign w_sel_on   = DIGITS'(1) << w_digit_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slot_cnt  <= '0;
            r_digit     <= '0;
            r_pend_data <= '0;
            r_pend_mode <= SEG_CONST;
            r_pend_cur  <= '0;
            r_act_data  <= '0;
            r_act_mode  <= SEG_CONST;
            r_act_cur   <= '0;
            frame_start <= 1'b0;
            seg_select  <= SEL_OFF;
            seg_out     <= 8'h00;
        end else begin
            r_slot_cnt  <= w_slot_last ? '0 : r_slot_cnt + 1'b1;
            r_digit     <= w_digit_nxt;
            frame_start <= w_boundary;
            if (load) begin
                r_pend_data <= disp_data;
                r_pend_mode <= w_mode_in;
                r_pend_cur  <= cursor;
            end
            if (w_boundary) begin
                r_act_data <= load ? disp_data : r_pend_data;
                r_act_mode <= w_mode_nxt;
                r_act_cur  <= load ? cursor : r_pend_cur;
            end
            seg_select <= (w_state_nxt == ST_ON) ? (w_sel_on ^ SEL_OFF) : SEL_OFF;
            seg_out    <= (w_state_nxt == ST_ON && !w_gate_off) ? w_pat : 8'h00;
        end
    end

    seg_flash_timer #(
        .FLASH_FRAMES (FLASH_FRAMES),
        .FLASH_COUNT  (FLASH_COUNT)
    ) u_flash (
        .clk          (clk),
        .reset        (reset),
        .i_tick       (w_boundary),
        .i_mode_chg   (w_mode_chg),
        .i_flash_en   ((r_act_mode == SEG_FLASH) || (r_act_mode == SEG_CURSOR)),
        .i_blink_en   (r_act_mode == SEG_FLASH),
        .o_phase_on   (w_phase_on),
        .o_flash_done (flash_done)
    );

endmodule
